pdp_fp17_lane_fork: RTL and testbench
=====================================

Name: pdp_fp17_lane_fork

Overview:
- Transmit-side lane distributor for the PDP fp17 datapath.
- Takes one packed multi-lane beat (LANES x 17-bit fp17 operands) on a single valid/ready handshake.
- Fans the beat out to LANES independent per-lane valid/ready consumers, such as the per-lane HLS fp17 adders.
- Each lane may accept in a different cycle; the upstream beat retires only when every lane has taken its slice.

Parameters:
- LANES, 4, number of fp17 lanes per beat.
- LANE_W, 17, width of one lane payload.
- CNT_W, 16, width of the retired-beat counter.

Ports:
- nvdla_core_clk  in  1  core clock; all state updates on rising edge.
- nvdla_core_rst  in  1  asynchronous, active-high reset.
- fork_in_pvld  in  1  upstream beat valid.
- fork_in_prdy  out  1  upstream beat ready.
- fork_in_pd  in  LANES*LANE_W  packed beat; lane i = bits [i*LANE_W +: LANE_W].
- fork_out_pvld  out  LANES  per-lane valid.
- fork_out_prdy  in  LANES  per-lane ready.
- fork_out_pd  out  LANES*LANE_W  per-lane payload, same packing as fork_in_pd.
- fork_partial  out  1  held beat has been taken by some, but not all, lanes.
- fork_beat_cnt  out  CNT_W  count of fully retired beats.

Behaviour:
- State: data_q[LANES*LANE_W], full_q, done_q[LANES], cnt_q[CNT_W].
- Reset (async, while nvdla_core_rst=1), all state cleared:
  - data_q=0, full_q=0, done_q=0, cnt_q=0.
  - Outputs: fork_out_pvld=0, fork_out_pd=0, fork_partial=0, fork_beat_cnt=0, fork_in_prdy=1.
- Reset mid-beat discards the held beat and any partial lane progress. Lanes that already took their slice are not replayed.
- Combinational definitions:
  - lane_fire[i] = fork_out_pvld[i] & fork_out_prdy[i].
  - complete = full_q & (&(done_q | lane_fire)).
  - fork_out_pvld[i] = full_q & ~done_q[i].
  - fork_out_pd = data_q.
  - fork_in_prdy = ~full_q | complete.
  - in_fire = fork_in_pvld & fork_in_prdy.
  - fork_partial = full_q & (|done_q).
  - fork_beat_cnt = cnt_q.
- fork_in_prdy depends combinationally on fork_out_prdy. This path is intentional and gives full throughput.
- Sequential updates, in priority order:
  1. in_fire: data_q <= fork_in_pd; full_q <= 1; done_q <= 0. This covers both the empty case and the complete-and-reload case in the same cycle.
  2. else if complete: full_q <= 0; done_q <= 0; data_q holds.
  3. else: done_q <= done_q | lane_fire.
- Counter: if complete, cnt_q <= cnt_q + 1, wrapping 2^CNT_W-1 -> 0. This is independent of in_fire.
- Latency and throughput:
  - Beat accepted at edge N -> fork_out_pvld asserted after edge N.
  - With all fork_out_prdy=1 continuously: 1 beat/cycle, no bubbles.
- Handshake rules:
  - Once fork_out_pvld[i]=1 it stays 1, and fork_out_pd stays stable, until lane_fire[i].
  - After lane i fires it deasserts; each lane slice is delivered exactly once per beat.
  - fork_out_prdy with fork_out_pvld=0 has no effect.
- Boundary cases:
  - Upstream fork_in_pvld ignored when fork_in_prdy=0; no beat is lost or duplicated.
  - Last missing lane fires in the same cycle a new beat is offered: old beat retires, new beat loads, done_q clears, and all lanes are valid the next cycle.
  - All lanes fire the same cycle: retires in one cycle, fork_partial never asserts.
  - fork_in_pd with X is tolerated only when fork_in_pvld=0.

Test Plan:
- Reset then idle, all ready -> fork_in_prdy=1, fork_out_pvld=4'b0000, fork_beat_cnt=0.
- Stream 8 beats back-to-back, fork_out_prdy=4'hF, lane pd = beat*4+i -> fork_out_pvld=4'hF every cycle from cycle 1, no bubbles, values in order, fork_beat_cnt=8.
- Beat 0x..., fork_out_prdy sequence 4'b0001, 4'b0100, 4'b0010, 4'b1000 -> fork_out_pvld 4'hF, 4'hE, 4'hA, 4'h8; fork_partial=1 for 3 cycles; fork_in_prdy=1 only in the 4th cycle; fork_beat_cnt increments once.
- Lane 3 held not-ready for 10 cycles with a second beat pending -> fork_out_pvld=4'h8 and lane-3 pd stable throughout; second beat accepted the cycle lane 3 fires; next cycle fork_out_pvld=4'hF with the new data.
- Assert nvdla_core_rst asynchronously mid-beat, after lanes 0-1 have fired -> outputs clear immediately; after release, the previous beat is not replayed and the next beat is delivered on all 4 lanes.
- Force cnt_q to 16'hFFFF, retire 1 beat -> fork_beat_cnt=0.

Source files
------------

// File: rtl/pdp_fp17_lane_fork.sv
// Lane distributor: one packed LANES x LANE_W beat in, LANES independent
// valid/ready lane outputs. The held beat retires once every lane has taken
// its slice. A new beat may load in the same cycle the old one completes.
module pdp_fp17_lane_fork #(
    parameter int LANES  = 4,
    parameter int LANE_W = 17,
    parameter int CNT_W  = 16
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic                    fork_in_pvld,
    output logic                    fork_in_prdy,
    input  logic [LANES*LANE_W-1:0] fork_in_pd,
    output logic [LANES-1:0]        fork_out_pvld,
    input  logic [LANES-1:0]        fork_out_prdy,
    output logic [LANES*LANE_W-1:0] fork_out_pd,
    output logic                    fork_partial,
    output logic [CNT_W-1:0]        fork_beat_cnt
);

    logic [LANES*LANE_W-1:0] data_q, data_d;
    logic                    full_q, full_d;
    logic [LANES-1:0]        done_q, done_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [LANES-1:0]        lane_fire;
    logic                    complete;
    logic                    in_fire;

    // Handshake decode; ready upstream looks through to lane readies
    always_comb begin
        fork_out_pvld = {LANES{full_q}} & ~done_q;
        lane_fire     = fork_out_pvld & fork_out_prdy;
        complete      = full_q & (&(done_q | lane_fire));
        fork_in_prdy  = ~full_q | complete;
        in_fire       = fork_in_pvld & fork_in_prdy;
        fork_out_pd   = data_q;
        fork_partial  = full_q & (|done_q);
        fork_beat_cnt = cnt_q;
    end

    // Next-state: load beats priority over retire, else accumulate lane takes
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        done_d = done_q;
        cnt_d  = cnt_q;
        if (in_fire) begin
            data_d = fork_in_pd;
            full_d = 1'b1;
            done_d = '0;
        end else if (complete) begin
            full_d = 1'b0;
            done_d = '0;
        end else begin
            done_d = done_q | lane_fire;
        end
        if (complete) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            data_q <= '0;
            full_q <= 1'b0;
            done_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pdp_fp17_lane_fork.sv
// Directed bench for pdp_fp17_lane_fork with hand-computed expectations.
module tb_pdp_fp17_lane_fork;

    localparam int LANES  = 4;
    localparam int LANE_W = 17;
    localparam int CNT_W  = 16;
    localparam int PW     = LANES*LANE_W;

    logic             clk;
    logic             rst;
    logic             in_pvld;
    logic             in_prdy;
    logic [PW-1:0]    in_pd;
    logic [LANES-1:0] out_pvld;
    logic [LANES-1:0] out_prdy;
    logic [PW-1:0]    out_pd;
    logic             partial;
    logic [CNT_W-1:0] beat_cnt;

    int n_total = 0;
    int n_pass  = 0;

    pdp_fp17_lane_fork #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .fork_in_pvld   (in_pvld),
        .fork_in_prdy   (in_prdy),
        .fork_in_pd     (in_pd),
        .fork_out_pvld  (out_pvld),
        .fork_out_prdy  (out_prdy),
        .fork_out_pd    (out_pd),
        .fork_partial   (partial),
        .fork_beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat whose lane i carries base + i
    function automatic logic [PW-1:0] mk(input int base);
        logic [PW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = LANE_W'(base + i);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs change 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [PW-1:0] held_a;

    initial begin
        rst      = 1'b1;
        in_pvld  = 1'b0;
        in_pd    = '0;
        out_prdy = 4'hF;
        #12;
        chk("rst_in_prdy",  PW'(in_prdy),  PW'(1));
        chk("rst_out_pvld", PW'(out_pvld), PW'(0));
        chk("rst_out_pd",   out_pd,        '0);
        chk("rst_partial",  PW'(partial),  PW'(0));
        chk("rst_cnt",      PW'(beat_cnt), PW'(0));
        step();
        rst = 1'b0;
        step();
        chk("idle_in_prdy",  PW'(in_prdy),  PW'(1));
        chk("idle_out_pvld", PW'(out_pvld), PW'(0));

        // Back-to-back streaming, all lanes ready
        in_pvld = 1'b1;
        in_pd   = mk(0);
        #1;
        step();
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("strm_pvld_%0d", b), PW'(out_pvld), PW'(4'hF));
            chk($sformatf("strm_pd_%0d", b),   out_pd,        mk(b*4));
            chk($sformatf("strm_rdy_%0d", b),  PW'(in_prdy),  PW'(1));
            if (b < 7) in_pd = mk((b+1)*4);
            else in_pvld = 1'b0;
            step();
        end
        #1;
        chk("strm_drained", PW'(out_pvld), PW'(0));
        chk("strm_cnt",     PW'(beat_cnt), PW'(8));

        // Lanes accept one at a time
        out_prdy = 4'h0;
        in_pvld  = 1'b1;
        in_pd    = mk(32'h100);
        step();
        in_pvld  = 1'b0;
        out_prdy = 4'b0001;
        #1;
        chk("p1_pvld", PW'(out_pvld), PW'(4'hF));
        chk("p1_part", PW'(partial),  PW'(0));
        chk("p1_rdy",  PW'(in_prdy),  PW'(0));
        step();
        out_prdy = 4'b0100;
        #1;
        chk("p2_pvld", PW'(out_pvld), PW'(4'hE));
        chk("p2_part", PW'(partial),  PW'(1));
        chk("p2_rdy",  PW'(in_prdy),  PW'(0));
        step();
        out_prdy = 4'b0010;
        #1;
        chk("p3_pvld", PW'(out_pvld), PW'(4'hA));
        chk("p3_part", PW'(partial),  PW'(1));
        chk("p3_rdy",  PW'(in_prdy),  PW'(0));
        step();
        out_prdy = 4'b1000;
        #1;
        chk("p4_pvld", PW'(out_pvld), PW'(4'h8));
        chk("p4_part", PW'(partial),  PW'(1));
        chk("p4_rdy",  PW'(in_prdy),  PW'(1));
        step();
        #1;
        chk("p5_pvld", PW'(out_pvld), PW'(0));
        chk("p5_part", PW'(partial),  PW'(0));
        chk("p5_cnt",  PW'(beat_cnt), PW'(9));

        // Lane 3 stalls with a second beat pending
        out_prdy = 4'h0;
        in_pvld  = 1'b1;
        in_pd    = mk(32'h200);
        held_a   = mk(32'h200);
        step();
        out_prdy = 4'b0111;
        in_pd    = mk(32'h300);
        #1;
        chk("h0_pvld", PW'(out_pvld), PW'(4'hF));
        chk("h0_rdy",  PW'(in_prdy),  PW'(0));
        step();
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("h_pvld_%0d", c), PW'(out_pvld), PW'(4'h8));
            chk($sformatf("h_pd3_%0d", c),
                PW'(out_pd[3*LANE_W +: LANE_W]), PW'(held_a[3*LANE_W +: LANE_W]));
            chk($sformatf("h_rdy_%0d", c),  PW'(in_prdy),  PW'(0));
            step();
        end
        out_prdy = 4'b1000;
        #1;
        chk("h_fire_rdy", PW'(in_prdy), PW'(1));
        step();
        in_pvld  = 1'b0;
        out_prdy = 4'h0;
        #1;
        chk("h_new_pvld", PW'(out_pvld), PW'(4'hF));
        chk("h_new_pd",   out_pd,        mk(32'h300));
        chk("h_new_part", PW'(partial),  PW'(0));
        chk("h_cnt",      PW'(beat_cnt), PW'(10));
        out_prdy = 4'hF;
        step();
        #1;
        chk("h_cnt2", PW'(beat_cnt), PW'(11));

        // Asynchronous reset mid-beat
        out_prdy = 4'h0;
        in_pvld  = 1'b1;
        in_pd    = mk(32'h400);
        step();
        in_pvld  = 1'b0;
        out_prdy = 4'b0011;
        step();
        out_prdy = 4'h0;
        #1;
        chk("r_pre_pvld", PW'(out_pvld), PW'(4'hC));
        chk("r_pre_part", PW'(partial),  PW'(1));
        rst = 1'b1;
        #1;
        chk("r_pvld", PW'(out_pvld), PW'(0));
        chk("r_pd",   out_pd,        '0);
        chk("r_part", PW'(partial),  PW'(0));
        chk("r_rdy",  PW'(in_prdy),  PW'(1));
        chk("r_cnt",  PW'(beat_cnt), PW'(0));
        step();
        rst = 1'b0;
        step();
        #1;
        chk("r_noreplay", PW'(out_pvld), PW'(0));
        in_pvld = 1'b1;
        in_pd   = mk(32'h500);
        step();
        in_pvld  = 1'b0;
        out_prdy = 4'hF;
        #1;
        chk("r_next_pvld", PW'(out_pvld), PW'(4'hF));
        chk("r_next_pd",   out_pd,        mk(32'h500));
        step();
        #1;
        chk("r_next_cnt", PW'(beat_cnt), PW'(1));

        // Counter wrap
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        #1;
        chk("w_pre", PW'(beat_cnt), PW'(16'hFFFF));
        in_pvld = 1'b1;
        in_pd   = mk(32'h600);
        step();
        in_pvld = 1'b0;
        step();
        #1;
        chk("w_wrap", PW'(beat_cnt), PW'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
